fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the decode/register-read stage. It owns the program counter and issues requests to a synchronous-read instruction cache. It returns each instruction with its PC to decode, and asserts bubble whenever no valid instruction is present. It holds a returned instruction across downstream stalls and squashes in-flight fetches on a redirect from execute.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, issues requests to a
// synchronous-read instruction cache and hands each instruction with its PC
// to decode. A skid register holds a returned instruction across downstream
// stalls; a redirect from execute squashes everything in flight.
//
// Optional feature macro: FETCH_PERF_EN adds perf_fetched / perf_bubbles
// counters (instructions delivered, bubble cycles outside reset).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        icache_re,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_dout,
    input  logic        icache_stall,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        bubble
);

    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q,    resp_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic valid;
    logic advance;

    // An instruction is presentable if it sits in the skid register or the
    // cache has just returned data for the outstanding request.
    always_comb begin
        valid       = hold_valid_q | (resp_valid_q & ~icache_stall);
        bubble      = ~valid;
        pc          = resp_pc_q;
        icache_re   = ~rst;
        icache_addr = fetch_pc_q;
        advance     = ~rst & ~redirect & ~stall & ~icache_stall;
        if (hold_valid_q) begin
            instr = hold_instr_q;
        end else if (valid) begin
            instr = icache_dout;
        end else begin
            instr = NOP_INSTR;
        end
    end

    // Next-state selection: reset, redirect, downstream stall, cache miss,
    // then advance, with the first matching condition winning.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (rst) begin
            fetch_pc_d   = RESET_PC;
            resp_pc_d    = RESET_PC;
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
            hold_instr_d = NOP_INSTR;
        end else if (redirect) begin
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (stall) begin
            // Park the returned word so the cache is free to keep re-reading
            // fetch_pc without disturbing what decode sees.
            if (resp_valid_q && !icache_stall && !hold_valid_q) begin
                hold_instr_d = icache_dout;
                hold_valid_d = 1'b1;
                resp_valid_d = 1'b0;
            end
        end else if (!icache_stall) begin
            resp_pc_d    = fetch_pc_q;
            resp_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
            hold_valid_d = 1'b0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        fetch_pc_q   <= fetch_pc_d;
        resp_valid_q <= resp_valid_d;
        resp_pc_q    <= resp_pc_d;
        hold_valid_q <= hold_valid_d;
        hold_instr_q <= hold_instr_d;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    // Performance counters survive redirects and only clear on reset.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (rst) begin
            perf_fetched_d = 32'd0;
            perf_bubbles_d = 32'd0;
        end else begin
            if (advance && valid) begin
                perf_fetched_d = perf_fetched_q + 32'd1;
            end
            if (!valid) begin
                perf_bubbles_d = perf_bubbles_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        perf_fetched_q <= perf_fetched_d;
        perf_bubbles_q <= perf_bubbles_d;
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule
